// File: rtl/rca_pipe_adder_if.sv
// Operand and result channels of the pipelined ripple-carry adder/subtractor.
// The producer/consumer side uses the master modport, the adder uses slave.
interface rca_pipe_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor. A WIDTH-bit add is split into
// SEG_W-bit ripple segments with one register stage per segment; the segment
// carry and the not-yet-consumed operand bits travel with each slot.
// The whole pipeline advances together whenever the output slot is free or
// being retired, so in_ready never depends on in_valid.
module rca_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG_W = 4
) (
    input logic           clk,
    input logic           rst,
    rca_pipe_adder_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / SEG_W;

    if (SEG_W == 0 || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
        $error("rca_pipe_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    function automatic logic [SEG_W:0] ripple(
        input logic [SEG_W-1:0] x,
        input logic [SEG_W-1:0] y,
        input logic             ci
    );
        logic [SEG_W:0] r;
        logic           c;
        r = '0;
        c = ci;
        for (int unsigned i = 0; i < SEG_W; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        r[SEG_W] = c;
        return r;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Subtraction is a + ~b + ~cin, so cout reads as "no borrow".
    assign b_eff = bus.b ^ {WIDTH{bus.sub}};
    assign c0    = bus.cin ^ bus.sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned LO = k * SEG_W;
        localparam int unsigned HI = LO + SEG_W;

        logic [WIDTH-LO-1:0] op_a;
        logic [WIDTH-LO-1:0] op_b;
        logic                c_in;
        logic                v_in;
        logic [SEG_W:0]      rip;
        logic [HI-1:0]       res_nxt;
        logic                vld;
        logic [HI-1:0]       res;
        logic                carry;

        if (k == 0) begin : g_src
            assign op_a    = bus.a;
            assign op_b    = b_eff;
            assign c_in    = c0;
            assign v_in    = bus.in_valid;
            assign res_nxt = rip[SEG_W-1:0];
        end else begin : g_src
            assign op_a    = g_st[k-1].g_up.a_up;
            assign op_b    = g_st[k-1].g_up.b_up;
            assign c_in    = g_st[k-1].carry;
            assign v_in    = g_st[k-1].vld;
            assign res_nxt = {rip[SEG_W-1:0], g_st[k-1].res};
        end

        assign rip = ripple(op_a[SEG_W-1:0], op_b[SEG_W-1:0], c_in);

        // Stage slot: valid, accumulated low result bits and segment carry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld   <= 1'b0;
                res   <= '0;
                carry <= 1'b0;
            end else if (adv) begin
                vld   <= v_in;
                res   <= res_nxt;
                carry <= rip[SEG_W];
            end
        end

        if (k < STAGES - 1) begin : g_up
            logic [WIDTH-HI-1:0] a_up;
            logic [WIDTH-HI-1:0] b_up;

            // Operand bits still to be summed by later stages
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_up <= '0;
                    b_up <= '0;
                end else if (adv) begin
                    a_up <= op_a[WIDTH-LO-1:SEG_W];
                    b_up <= op_b[WIDTH-LO-1:SEG_W];
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_r;

            // Signed overflow: carry into MSB (a^b^sum at MSB) differs from carry out
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (adv) begin
                    ovf_r <= op_a[SEG_W-1] ^ op_b[SEG_W-1] ^ rip[SEG_W-1] ^ rip[SEG_W];
                end
            end
        end
    end

    assign adv           = bus.out_ready || !g_st[STAGES-1].vld;
    assign bus.in_ready  = adv;
    assign bus.out_valid = g_st[STAGES-1].vld;
    assign bus.sum       = g_st[STAGES-1].res;
    assign bus.cout      = g_st[STAGES-1].carry;
    assign bus.ovf       = g_st[STAGES-1].g_last.ovf_r;
endmodule

// File: doc/rca_pipe_adder.md
Name: rca_pipe_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 4-bit combinational RCA.
- Splits a WIDTH-bit add into SEG_W-bit ripple segments, one register stage per segment, with the carry registered between stages.
- Valid/ready handshake on both sides; drops into datapaths that need wide adds at high clock rates with backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG_W (elaboration error otherwise).
- SEG_W, 4, bits per ripple segment (per pipeline stage).
- STAGES, WIDTH/SEG_W, derived, not overridable; pipeline depth.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  operands accepted on edge where in_valid && in_ready
- a  in  WIDTH  operand A, unsigned/two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a-b-cin
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  raw carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, all stage data 0; out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 during/after reset once out_ready or !out_valid.
- Operand conditioning at input: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. Stage 0 computes segment 0 combinationally from a, b_eff, c0 and registers it.
- Stage k (0..STAGES-1) computes bits [k*SEG_W +: SEG_W] as a ripple of SEG_W full adders using the carry registered by stage k-1 (stage 0 uses c0). It registers: valid, result bits [0 .. (k+1)*SEG_W-1], carry out, and the unconsumed upper bits of a and b_eff.
- Last stage additionally registers ovf = carry into MSB XOR carry out of MSB. sum, cout and ovf are driven directly from the last-stage registers.
- Advance: adv = out_ready || !out_valid. When adv=1, every stage loads from its predecessor on the edge. Stage 0 loads with valid=in_valid. When adv=0, all stages hold.
- in_ready = adv (combinational). No combinational path from in_valid to in_ready.
- Latency: a transfer accepted on edge t appears with out_valid=1 after edge t+STAGES-1, provided adv stayed 1. Each stall cycle adds one cycle. STAGES=1 gives a plain registered adder.
- Throughput: one result per cycle with in_valid=1 and out_ready=1 continuously. Internal bubbles (in_valid=0) propagate as invalid slots and are not compressed.
- Stall: while out_valid=1 and out_ready=0, sum, cout and ovf hold stable and no stage changes. in_ready=0.
- Simultaneous: out_valid && out_ready && in_valid in the same cycle → result retired and new operand accepted on the same edge.
- Data in invalid slots is don't-care internally. Outputs change only when the last stage loads.
- Reset mid-operation: all in-flight results are discarded immediately; no partial result is ever presented.
- Mode and cin are sampled only at acceptance. Changing them while a transfer is in flight has no effect on it.

Test Plan:
- WIDTH=16, SEG_W=4: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → after 3 edges past acceptance, out_valid=1, sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 stages).
- a=0x7FFF, b=0x0001, cin=0, sub=0 → sum=0x8000, cout=0, ovf=1. Then a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0.
- Back-to-back: 8 consecutive transfers (a=i, b=2*i, i=0..7), out_ready=1 → 8 consecutive out_valid cycles with sum=3*i, in order, in_ready constantly 1.
- Backpressure: stream 6 transfers, hold out_ready=0 for 5 cycles once out_valid=1 → in_ready=0 and sum/cout/ovf stable throughout. After release, all 6 results appear in order with none lost or duplicated.
- Reset: assert rst with 3 transfers in flight → out_valid=0 and sum=0 asynchronously, with no stale result after release. The next transfer, a=0x1234, b=0x1111, cin=1, gives sum=0x2346.
- Parameter sweep: WIDTH=8/SEG_W=8 (STAGES=1, 1-cycle latency) and WIDTH=32/SEG_W=4. Random a, b, cin, sub against a reference model; check sum, cout and ovf on every result.
